// File: rtl/mydesign_seq.sv
// mydesign_seq: sequential form of F = ((A*B) + (C << i)) >> j.
// A radix-2 shift-add multiplier consumes one multiplier bit per clock. The
// adjust step then adds the shifted addend and applies the right shift. Both
// sides use valid/ready handshakes. ovf reports nonzero bits lost above
// bit 2*W-1 once the right shift has been applied.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand set A/B/C/i/j valid
//   in_ready   block can accept an operand set (high only in IDLE)
//   A, B, C    unsigned operands, W bits
//   i          left shift applied to C, SHW bits
//   j          right shift applied to the final sum, SHW bits
//   out_valid  F/ovf valid (high only in DONE)
//   out_ready  downstream accepts F
//   F          result, 2*W bits, holds its value until the next ADJ or reset
//   ovf        truncation flag for F
module mydesign_seq #(
  parameter int W   = 8,
  parameter int SHW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic [W-1:0]     C,
  input  logic [SHW-1:0]   i,
  input  logic [SHW-1:0]   j,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   F,
  output logic             ovf
);

  // The sum is wide enough for acc plus C shifted by the largest i, so
  // nothing is lost before the right shift.
  localparam int SW = 2*W + (1 << SHW);
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADJ  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [2*W-1:0]   a_r;
  logic [W-1:0]     b_r;
  logic [W-1:0]     c_r;
  logic [SHW-1:0]   i_r;
  logic [SHW-1:0]   j_r;
  logic [2*W-1:0]   acc_r;
  logic [CW-1:0]    cnt_r;
  logic [2*W-1:0]   f_r;
  logic             ovf_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [SW-1:0]    sum_s;
  logic [SW-1:0]    res_s;

  // Adjust-step arithmetic: add the shifted addend, then shift right.
  always_comb begin
    sum_s = SW'(acc_r) + (SW'(c_r) << i_r);
    res_s = sum_s >> j_r;
  end

  // Next-state logic for the handshake/multiply sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          state_s = MUL;
        end else begin
          state_s = IDLE;
        end
      end
      MUL: begin
        if (cnt_r == CW'(W - 1)) begin
          state_s = ADJ;
        end else begin
          state_s = MUL;
        end
      end
      ADJ: begin
        state_s = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register plus registered handshake flags, derived from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
    end
  end

  // Operand capture, shift-add multiply and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      c_r   <= '0;
      i_r   <= '0;
      j_r   <= '0;
      acc_r <= '0;
      cnt_r <= '0;
      f_r   <= '0;
      ovf_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            a_r   <= (2*W)'(A);
            b_r   <= B;
            c_r   <= C;
            i_r   <= i;
            j_r   <= j;
            acc_r <= '0;
            cnt_r <= '0;
          end
        end
        MUL: begin
          // The multiplicand moves up one place for each multiplier bit used.
          if (b_r[0]) begin
            acc_r <= acc_r + a_r;
          end
          a_r   <= a_r << 1;
          b_r   <= b_r >> 1;
          cnt_r <= cnt_r + CW'(1);
        end
        ADJ: begin
          f_r   <= res_s[2*W-1:0];
          ovf_r <= |res_s[SW-1:2*W];
        end
        DONE: begin
          f_r   <= f_r;
          ovf_r <= ovf_r;
        end
        default: begin
          acc_r <= '0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign F         = f_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_mydesign_seq.sv
module tb_mydesign_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  a = 8'd0, b = 8'd0, c = 8'd0;
  logic [2:0]  i = 3'd0, j = 3'd0;
  logic        in_ready, out_valid, ovf;
  logic [15:0] f;

  logic        in_valid4 = 1'b0;
  logic        out_ready4 = 1'b1;
  logic [3:0]  a4 = 4'd0, b4 = 4'd0, c4 = 4'd0;
  logic [1:0]  i4 = 2'd0, j4 = 2'd0;
  logic        in_ready4, out_valid4, ovf4;
  logic [7:0]  f4;

  int checks = 0;
  int failures = 0;

  mydesign_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .C(c), .i(i), .j(j),
    .out_valid(out_valid), .out_ready(out_ready), .F(f), .ovf(ovf)
  );

  mydesign_seq #(.W(4), .SHW(2)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .A(a4), .B(b4), .C(c4), .i(i4), .j(j4),
    .out_valid(out_valid4), .out_ready(out_ready4), .F(f4), .ovf(ovf4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a, b, c;
    logic [2:0]  i, j;
    logic [15:0] f;
    logic        ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the formula evaluated with wide integer arithmetic.
  function automatic void model(input int w, input longint unsigned ma, mb, mc,
                                input int mi, mj,
                                output longint unsigned mf, output logic movf);
    longint unsigned s, r;
    s = ma * mb + (mc << mi);
    r = s >> mj;
    mf = r & ((64'd1 << (2 * w)) - 64'd1);
    movf = ((r >> (2 * w)) != 64'd0);
  endfunction

  task automatic run8(input logic [7:0] ta, tb, tc, input logic [2:0] ti, tj,
                      input int stall, output logic [15:0] rf, output logic rovf,
                      output int lat);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    a = ta; b = tb; c = tc; i = ti; j = tj; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
    i = 3'($urandom); j = 3'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rf = f;
    rovf = ovf;
    if (stall > 0) begin
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        check("stall_out_valid", out_valid, 1);
        check("stall_F", f, rf);
        check("stall_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
  endtask

  task automatic run4(input logic [3:0] ta, tb, tc, input logic [1:0] ti, tj,
                      output logic [7:0] rf, output logic rovf, output int lat);
    @(negedge clk);
    a4 = ta; b4 = tb; c4 = tc; i4 = ti; j4 = tj; in_valid4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rf = f4;
    rovf = ovf4;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0]     rf;
    logic [7:0]      rf4;
    logic            rovf, movf;
    int              lat;
    longint unsigned mf;
    logic [7:0]      ra, rb, rc;
    logic [2:0]      ri, rj;
    logic [3:0]      qa, qb, qc;
    logic [1:0]      qi, qj;

    vecs[0] = '{8'h06, 8'h06, 8'h06, 3'd1, 3'd1, 16'h0018, 1'b0};
    vecs[1] = '{8'h01, 8'h01, 8'h01, 3'd1, 3'd1, 16'h0001, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 3'd0, 3'd0, 16'hFF00, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 3'd7, 3'd7, 16'h02FB, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 8'hFF, 3'd7, 3'd0, 16'h7D81, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 16'h0000, 1'b0};
    vecs[6] = '{8'h01, 8'h01, 8'h00, 3'd0, 3'd7, 16'h0000, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_F", f, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready4", in_ready4, 1);
    rst = 1'b0;

    // Directed table
    for (int n = 0; n < 7; n++) begin
      run8(vecs[n].a, vecs[n].b, vecs[n].c, vecs[n].i, vecs[n].j, 0, rf, rovf, lat);
      check("vec_F", rf, vecs[n].f);
      check("vec_ovf", rovf, vecs[n].ovf);
      check("vec_latency", lat, 9);
    end

    // Backpressure: 5 stalled cycles in DONE with a competing in_valid
    run8(8'h06, 8'h06, 8'h06, 3'd1, 3'd1, 5, rf, rovf, lat);
    check("bp_F", rf, 16'h0018);
    check("bp_F_after", f, 16'h0018);

    // Randomized against the model, random downstream stalls
    for (int n = 0; n < 30; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom);
      ri = 3'($urandom); rj = 3'($urandom);
      model(8, ra, rb, rc, ri, rj, mf, movf);
      run8(ra, rb, rc, ri, rj, $urandom_range(0, 2), rf, rovf, lat);
      check("rand_F", rf, mf);
      check("rand_ovf", rovf, movf);
      check("rand_latency", lat, 9);
    end

    // Reset mid-MUL, four edges after accept; F is nonzero beforehand
    run8(8'h01, 8'h01, 8'h01, 3'd1, 3'd1, 0, rf, rovf, lat);
    @(negedge clk);
    a = 8'h06; b = 8'h06; c = 8'h06; i = 3'd1; j = 3'd1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_F", f, 0);
    check("mid_rst_ovf", ovf, 0);
    run8(8'h06, 8'h06, 8'h06, 3'd1, 3'd1, 0, rf, rovf, lat);
    check("after_rst_F", rf, 16'h0018);
    check("after_rst_latency", lat, 9);

    // W=4, SHW=2 instance
    run4(4'hF, 4'hF, 4'hF, 2'd3, 2'd0, rf4, rovf, lat);
    check("w4_F", rf4, 8'h59);
    check("w4_ovf", rovf, 1);
    check("w4_latency", lat, 5);
    for (int n = 0; n < 10; n++) begin
      qa = 4'($urandom); qb = 4'($urandom); qc = 4'($urandom);
      qi = 2'($urandom); qj = 2'($urandom);
      model(4, qa, qb, qc, qi, qj, mf, movf);
      run4(qa, qb, qc, qi, qj, rf4, rovf, lat);
      check("w4_rand_F", rf4, mf);
      check("w4_rand_ovf", rovf, movf);
      check("w4_rand_latency", lat, 5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
